// File: rtl/tb_data_bus_router.sv
// ---------------------------------------------------------------------------
// tb_data_bus_router
//   Sequential data-bus router placed directly behind the zeroriscy data port
//   in the HWPE simulation top. Each core request is decoded to one of four
//   targets (HWPE peripheral, stack memory, TCDM memory, internal MMIO).
//   Outstanding transactions are tracked in a small FIFO of target codes so
//   responses return in order and never mix between targets.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   data_*                       core-side request/response handshake
//   {periph,stack,tcdm}_*        target-side request/response handshakes
//   exit_valid_o / exit_code_o   sticky exit flag and last written exit code
//   char_valid_o / char_o        one-cycle putchar strobe and character
//   protocol_err_o               sticky flag: unexpected response observed
//
// Build option
//   TB_DATA_BUS_ROUTER_TRACE_EN  when defined, prints one line per granted
//                                request and per response, and echoes
//                                putchar characters.
// ---------------------------------------------------------------------------
module tb_data_bus_router #(
  parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
  parameter int unsigned MAX_OUTSTANDING    = 2,
  parameter logic [31:0] MMIO_BASE          = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // core side
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  // HWPE peripheral target
  output logic        periph_req_o,
  input  logic        periph_gnt_i,
  output logic [31:0] periph_add_o,
  output logic        periph_wen_o,
  output logic [3:0]  periph_be_o,
  output logic [31:0] periph_data_o,
  input  logic [31:0] periph_r_data_i,
  input  logic        periph_r_valid_i,
  // stack memory target
  output logic        stack_req_o,
  input  logic        stack_gnt_i,
  output logic [31:0] stack_add_o,
  output logic        stack_wen_o,
  output logic [3:0]  stack_be_o,
  output logic [31:0] stack_data_o,
  input  logic [31:0] stack_r_data_i,
  input  logic        stack_r_valid_i,
  // TCDM memory target
  output logic        tcdm_req_o,
  input  logic        tcdm_gnt_i,
  output logic [31:0] tcdm_add_o,
  output logic        tcdm_wen_o,
  output logic [3:0]  tcdm_be_o,
  output logic [31:0] tcdm_data_o,
  input  logic [31:0] tcdm_r_data_i,
  input  logic        tcdm_r_valid_i,
  // internal MMIO
  output logic        exit_valid_o,
  output logic [31:0] exit_code_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  output logic        protocol_err_o
);

  typedef enum logic [1:0] {
    TGT_STACK  = 2'd0,
    TGT_TCDM   = 2'd1,
    TGT_PERIPH = 2'd2,
    TGT_MMIO   = 2'd3
  } tgt_e;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  tgt_e        fifo_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  tgt_e        last_q, last_d;
  logic        mmio_rsp_q, mmio_rsp_d, mmio_err_q, mmio_err_d;
  logic        exit_valid_q, exit_valid_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        char_valid_q, char_valid_d;
  logic [7:0]  char_q, char_d;
  logic        perr_q, perr_d;

  tgt_e        sel, head;
  logic        accept, sel_gnt, push, pop, head_rv, stray;
  logic        mmio_hit, mmio_exit, mmio_char;

  // Address decode, first match wins.
  always_comb begin
    sel = TGT_TCDM;
    if (data_addr_i[31:8] == MMIO_BASE[31:8])  sel = TGT_MMIO;
    else if (data_addr_i[HWPE_ADDR_BASE_BIT])  sel = TGT_PERIPH;
    else if (data_addr_i[31:24] == 8'h00)      sel = TGT_STACK;
  end

  // A new request is only accepted while the FIFO has room and it goes to the
  // same target as everything still outstanding; switching targets waits for
  // the pipe to empty so responses can never overtake one another.
  assign accept = (count_q < MAX_CNT) && ((count_q == 3'd0) || (sel == last_q));

  always_comb begin
    sel_gnt = 1'b1;  // MMIO grants as soon as the request is accepted
    case (sel)
      TGT_STACK:  sel_gnt = stack_gnt_i;
      TGT_TCDM:   sel_gnt = tcdm_gnt_i;
      TGT_PERIPH: sel_gnt = periph_gnt_i;
      default:    sel_gnt = 1'b1;
    endcase
  end

  assign data_gnt_o   = accept & sel_gnt;
  assign push         = data_req_i & data_gnt_o;

  assign stack_req_o  = data_req_i & accept & (sel == TGT_STACK);
  assign tcdm_req_o   = data_req_i & accept & (sel == TGT_TCDM);
  assign periph_req_o = data_req_i & accept & (sel == TGT_PERIPH);

  assign stack_add_o   = data_addr_i;
  assign periph_add_o  = data_addr_i;
  assign tcdm_add_o    = {8'h00, data_addr_i[23:0]};
  assign stack_wen_o   = ~data_we_i;
  assign tcdm_wen_o    = ~data_we_i;
  assign periph_wen_o  = ~data_we_i;
  assign stack_be_o    = data_be_i;
  assign tcdm_be_o     = data_be_i;
  assign periph_be_o   = data_be_i;
  assign stack_data_o  = data_wdata_i;
  assign tcdm_data_o   = data_wdata_i;
  assign periph_data_o = data_wdata_i;

  // Response path: only the target at the FIFO head may answer.
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    head_rv      = 1'b0;
    data_rdata_o = 32'h0;
    case (head)
      TGT_STACK:  begin head_rv = stack_r_valid_i;  data_rdata_o = stack_r_data_i;  end
      TGT_TCDM:   begin head_rv = tcdm_r_valid_i;   data_rdata_o = tcdm_r_data_i;   end
      TGT_PERIPH: begin head_rv = periph_r_valid_i; data_rdata_o = periph_r_data_i; end
      default:    begin head_rv = mmio_rsp_q;       data_rdata_o = 32'h0;           end
    endcase
  end

  assign data_rvalid_o = (count_q != 3'd0) & head_rv;
  assign data_err_o    = data_rvalid_o & (head == TGT_MMIO) & mmio_err_q;
  assign pop           = data_rvalid_o;

  // A valid from a target that is not at the head (or with nothing pending).
  assign stray = (stack_r_valid_i  & ((count_q == 3'd0) | (head != TGT_STACK)))
               | (tcdm_r_valid_i   & ((count_q == 3'd0) | (head != TGT_TCDM)))
               | (periph_r_valid_i & ((count_q == 3'd0) | (head != TGT_PERIPH)));

  // MMIO side effects take place at grant; the response follows next cycle.
  assign mmio_hit  = push & (sel == TGT_MMIO);
  assign mmio_exit = mmio_hit & data_we_i & (data_addr_i[7:0] == 8'h00);
  assign mmio_char = mmio_hit & data_we_i & (data_addr_i[7:0] == 8'h04);

  always_comb begin
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    wr_ptr_d     = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    last_d       = push ? sel : last_q;
    mmio_rsp_d   = mmio_hit;
    mmio_err_d   = mmio_hit & ~(mmio_exit | mmio_char);
    exit_valid_d = exit_valid_q | mmio_exit;
    exit_code_d  = mmio_exit ? data_wdata_i : exit_code_q;
    char_valid_d = mmio_char;
    char_d       = mmio_char ? data_wdata_i[7:0] : char_q;
    perr_d       = perr_q | stray;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= TGT_STACK;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      last_q       <= TGT_STACK;
      mmio_rsp_q   <= 1'b0;
      mmio_err_q   <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= 32'h0;
      char_valid_q <= 1'b0;
      char_q       <= 8'h0;
      perr_q       <= 1'b0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= sel;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_q       <= last_d;
      mmio_rsp_q   <= mmio_rsp_d;
      mmio_err_q   <= mmio_err_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
      char_valid_q <= char_valid_d;
      char_q       <= char_d;
      perr_q       <= perr_d;
    end
  end

  assign exit_valid_o   = exit_valid_q;
  assign exit_code_o    = exit_code_q;
  assign char_valid_o   = char_valid_q;
  assign char_o         = char_q;
  assign protocol_err_o = perr_q;

`ifdef TB_DATA_BUS_ROUTER_TRACE_EN
  function automatic string tgt_name(tgt_e t);
    case (t)
      TGT_STACK:  return "stack";
      TGT_TCDM:   return "tcdm";
      TGT_PERIPH: return "periph";
      default:    return "mmio";
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (!rst_i && push)
      $display("%0t router req  %s %s addr=%h wdata=%h be=%b", $time, tgt_name(sel),
               data_we_i ? "W" : "R", data_addr_i, data_wdata_i, data_be_i);
    if (!rst_i && data_rvalid_o)
      $display("%0t router rsp  %s rdata=%h err=%b", $time, tgt_name(head),
               data_rdata_o, data_err_o);
    if (!rst_i && mmio_char)
      $write("%c", data_wdata_i[7:0]);
  end
`else
  // Default build: no trace output.
`endif

endmodule

// File: tb/tb_tb_data_bus_router.sv
module tb_tb_data_bus_router;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core side
  logic        data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  // targets (index 0 stack, 1 tcdm, 2 periph)
  logic        stack_req, tcdm_req, periph_req;
  logic        stack_wen, tcdm_wen, periph_wen;
  logic [3:0]  stack_be, tcdm_be, periph_be;
  logic [31:0] stack_add, tcdm_add, periph_add;
  logic [31:0] stack_dat, tcdm_dat, periph_dat;
  logic [2:0]  t_req, t_gnt, t_rv, t_wen;
  logic [31:0] t_add [3];
  logic [31:0] t_dat [3];
  logic [3:0]  t_be  [3];
  logic [31:0] t_rdata [3];
  logic        inj_rv;
  // MMIO / flags
  logic        exit_valid, char_valid, perr;
  logic [31:0] exit_code;
  logic [7:0]  char_v;

  assign t_req = {periph_req, tcdm_req, stack_req};
  assign t_wen = {periph_wen, tcdm_wen, stack_wen};
  assign t_add[0] = stack_add;  assign t_add[1] = tcdm_add;  assign t_add[2] = periph_add;
  assign t_dat[0] = stack_dat;  assign t_dat[1] = tcdm_dat;  assign t_dat[2] = periph_dat;
  assign t_be[0]  = stack_be;   assign t_be[1]  = tcdm_be;   assign t_be[2]  = periph_be;

  tb_data_bus_router dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_err_o(data_err), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
    .periph_req_o(periph_req), .periph_gnt_i(t_gnt[2]), .periph_add_o(periph_add),
    .periph_wen_o(periph_wen), .periph_be_o(periph_be), .periph_data_o(periph_dat),
    .periph_r_data_i(t_rdata[2]), .periph_r_valid_i(t_rv[2] | inj_rv),
    .stack_req_o(stack_req), .stack_gnt_i(t_gnt[0]), .stack_add_o(stack_add),
    .stack_wen_o(stack_wen), .stack_be_o(stack_be), .stack_data_o(stack_dat),
    .stack_r_data_i(t_rdata[0]), .stack_r_valid_i(t_rv[0]),
    .tcdm_req_o(tcdm_req), .tcdm_gnt_i(t_gnt[1]), .tcdm_add_o(tcdm_add),
    .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be), .tcdm_data_o(tcdm_dat),
    .tcdm_r_data_i(t_rdata[1]), .tcdm_r_valid_i(t_rv[1]),
    .exit_valid_o(exit_valid), .exit_code_o(exit_code),
    .char_valid_o(char_valid), .char_o(char_v), .protocol_err_o(perr)
  );

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- target models ----------------
  typedef struct { int tgt; logic [31:0] data; int due; } rsp_t;
  rsp_t        rq[$];
  logic [31:0] smem [logic [31:0]];
  int          lat [3];
  int          cyc = 0;
  bit          flush;
  logic [2:0]  s_hs, s_rv;
  logic [31:0] s_add [3];
  logic [31:0] s_wd  [3];
  logic [2:0]  s_we;

  function automatic int find_tgt(int t);
    foreach (rq[i]) if (rq[i].tgt == t) return i;
    return -1;
  endfunction

  // Capture handshakes mid-cycle; they complete at the coming rising edge.
  always @(negedge clk) begin
    s_hs = t_req & t_gnt;
    s_rv = t_rv;
    s_we = ~t_wen;
    for (int t = 0; t < 3; t++) begin
      s_add[t] = t_add[t];
      s_wd[t]  = t_dat[t];
    end
  end

  always @(posedge clk) begin
    int   idx;
    rsp_t r;
    #1;
    cyc++;
    if (flush) begin
      rq.delete();
      t_rv = 3'b000;
    end else begin
      for (int t = 0; t < 3; t++)
        if (s_rv[t]) begin
          idx = find_tgt(t);
          if (idx >= 0) rq.delete(idx);
        end
      for (int t = 0; t < 3; t++)
        if (s_hs[t]) begin
          r.tgt = t;
          r.due = cyc + lat[t] - 1;
          if (s_we[t]) begin
            r.data = 32'h0;
            if (t == 0) smem[s_add[0]] = s_wd[0];
          end else if (t == 0) begin
            r.data = smem.exists(s_add[0]) ? smem[s_add[0]] : 32'h0;
          end else begin
            r.data = s_add[t] ^ 32'h5A5A_0000;
          end
          rq.push_back(r);
        end
      for (int t = 0; t < 3; t++) begin
        idx = find_tgt(t);
        t_rv[t]    = (idx >= 0) && (rq[idx].due <= cyc);
        t_rdata[t] = (idx >= 0) ? rq[idx].data : 32'h0;
      end
    end
  end

  // ---------------- scoreboard / monitors ----------------
  typedef struct { logic [31:0] rd; logic err; } exp_t;
  exp_t sb[$];
  int   rv_cycs[$];
  int   nchar = 0;
  logic [7:0] last_char = 8'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && data_rvalid) begin
      rv_cycs.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rdata", data_rdata, e.rd);
        chk("err", {31'b0, data_err}, {31'b0, e.err});
      end
    end
    if (!rst && char_valid) begin
      nchar++;
      last_char = char_v;
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        output int gcyc);
    bit   got;
    exp_t e;
    got  = 0;
    gcyc = -1;
    @(posedge clk); #1;
    data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd; data_be = be;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (data_gnt) begin
        got = 1; gcyc = cyc;
        e.rd = exp_rd; e.err = exp_err;
        sb.push_back(e);
      end
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
  endtask

  function automatic logic [2:0] onehot(int t);
    return (t == 3) ? 3'b000 : 3'(1 << t);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          tgt;
    logic [31:0] add;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t vec [12];

  initial begin
    int g, g0, g1, g2, gt, bad;
    bit got;
    exp_t e;

    vec[0]  = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_1000, 32'h0,         1'b0};
    vec[1]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0};
    vec[2]  = '{1'b0, 32'h1000_0040, 32'h0,         4'hF, 1, 32'h0000_0040, 32'h5A5A_0040, 1'b0};
    vec[3]  = '{1'b0, 32'h0010_0000, 32'h0,         4'hF, 2, 32'h0010_0000, 32'h5A4A_0000, 1'b0};
    vec[4]  = '{1'b1, 32'h0010_0004, 32'h1122_3344, 4'h3, 2, 32'h0010_0004, 32'h0,         1'b0};
    vec[5]  = '{1'b0, 32'h12F0_0010, 32'h0,         4'hF, 2, 32'h12F0_0010, 32'h48AA_0010, 1'b0};
    vec[6]  = '{1'b0, 32'h8000_0100, 32'h0,         4'hF, 1, 32'h0000_0100, 32'h5A5A_0100, 1'b0};
    vec[7]  = '{1'b0, 32'h8010_0000, 32'h0,         4'hF, 2, 32'h8010_0000, 32'hDA4A_0000, 1'b0};
    vec[8]  = '{1'b0, 32'h0000_2000, 32'h0,         4'hF, 0, 32'h0000_2000, 32'h0,         1'b0};
    vec[9]  = '{1'b1, 32'h0000_203C, 32'hA5A5_A5A5, 4'hF, 0, 32'h0000_203C, 32'h0,         1'b0};
    vec[10] = '{1'b0, 32'h0000_203C, 32'h0,         4'hF, 0, 32'h0000_203C, 32'hA5A5_A5A5, 1'b0};
    vec[11] = '{1'b1, 32'h8000_00F0, 32'h0000_0001, 4'hF, 3, 32'h0,         32'h0,         1'b1};

    rst = 1'b1; flush = 1'b1; inj_rv = 1'b0; t_gnt = 3'b111; t_rv = 3'b000;
    for (int t = 0; t < 3; t++) begin t_rdata[t] = 32'h0; lat[t] = 1; end
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", {31'b0, data_rvalid}, 32'd0);
    chk("rst_exit_valid", {31'b0, exit_valid}, 32'd0);
    chk("rst_exit_code", exit_code, 32'd0);
    chk("rst_char_valid", {31'b0, char_valid}, 32'd0);
    chk("rst_char", {24'b0, char_v}, 32'd0);
    chk("rst_perr", {31'b0, perr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;

    // Single transactions through every decode path.
    foreach (vec[i]) begin
      do_req(vec[i].we, vec[i].addr, vec[i].wd, vec[i].be, vec[i].rd, vec[i].err, g);
      chk($sformatf("v%0d_req", i), {29'b0, t_req}, {29'b0, onehot(vec[i].tgt)});
      if (vec[i].tgt != 3) begin
        chk($sformatf("v%0d_add", i), t_add[vec[i].tgt], vec[i].add);
        chk($sformatf("v%0d_wen", i), {31'b0, t_wen[vec[i].tgt]}, {31'b0, ~vec[i].we});
        chk($sformatf("v%0d_be", i), {28'b0, t_be[vec[i].tgt]}, {28'b0, vec[i].be});
        chk($sformatf("v%0d_wdata", i), t_dat[vec[i].tgt], vec[i].wd);
      end
      rv_cycs.delete();
      idle();
      drain();
      if (vec[i].tgt == 3 && rv_cycs.size() > 0) chk("mmio_latency", rv_cycs[0] - g, 32'd1);
    end
    chk("perr_after_table", {31'b0, perr}, 32'd0);

    // Three pipelined tcdm reads against a slow target and a depth-2 FIFO.
    lat[1] = 5;
    rv_cycs.delete();
    do_req(1'b0, 32'h1000_0100, 32'h0, 4'hF, 32'h5A5A_0100, 1'b0, g0);
    do_req(1'b0, 32'h1000_0104, 32'h0, 4'hF, 32'h5A5A_0104, 1'b0, g1);
    do_req(1'b0, 32'h1000_0108, 32'h0, 4'hF, 32'h5A5A_0108, 1'b0, g2);
    idle();
    drain();
    chk("pipe_second_gnt", g1 - g0, 32'd1);
    chk("pipe_rv_count", rv_cycs.size(), 32'd3);
    if (rv_cycs.size() == 3) begin
      chk("pipe_first_rv", rv_cycs[0], g0 + 5);
      chk("pipe_third_gnt", g2, rv_cycs[0] + 1);
    end
    lat[1] = 1;

    // Stack read outstanding, then a tcdm request: held until the stack pops.
    lat[0] = 4;
    rv_cycs.delete();
    do_req(1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, g);
    @(posedge clk); #1;
    data_addr = 32'h1000_0200; data_we = 1'b0;
    got = 0; bad = 0; gt = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (data_gnt) begin
        got = 1; gt = cyc;
        e.rd = 32'h5A5A_0200; e.err = 1'b0;
        sb.push_back(e);
      end else if (tcdm_req) bad++;
    end
    chk("switch_granted", {31'b0, got}, 32'd1);
    chk("switch_req_held_low", bad, 32'd0);
    idle();
    drain();
    if (rv_cycs.size() > 0) chk("switch_gnt_after_pop", gt, rv_cycs[0] + 1);
    lat[0] = 1;

    // MMIO: exit code, putchar, error offsets.
    nchar = 0;
    do_req(1'b1, 32'h8000_0000, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, g); idle(); drain();
    chk("exit_valid_1", {31'b0, exit_valid}, 32'd1);
    chk("exit_code_1", exit_code, 32'hCAFE_0001);
    do_req(1'b1, 32'h8000_0004, 32'h0000_0142, 4'hF, 32'h0, 1'b0, g); idle(); drain();
    chk("char_strobes", nchar, 32'd1);
    chk("char_value", {24'b0, last_char}, 32'h42);
    do_req(1'b1, 32'h8000_0000, 32'h0, 4'hF, 32'h0, 1'b0, g); idle(); drain();
    chk("exit_valid_2", {31'b0, exit_valid}, 32'd1);
    chk("exit_code_2", exit_code, 32'h0);
    do_req(1'b0, 32'h8000_0008, 32'h0, 4'hF, 32'h0, 1'b1, g); idle(); drain();
    do_req(1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'h0, 1'b1, g); idle(); drain();
    chk("char_strobes_final", nchar, 32'd1);
    chk("perr_before_inject", {31'b0, perr}, 32'd0);

    // Stray periph response with nothing outstanding.
    @(posedge clk); #1; inj_rv = 1'b1;
    @(posedge clk); #1; inj_rv = 1'b0;
    @(negedge clk);
    chk("perr_set", {31'b0, perr}, 32'd1);
    repeat (3) @(negedge clk);
    chk("perr_sticky", {31'b0, perr}, 32'd1);

    // Asynchronous reset in the middle of a tcdm burst.
    lat[1] = 6;
    do_req(1'b0, 32'h1000_0300, 32'h0, 4'hF, 32'h5A5A_0300, 1'b0, g);
    do_req(1'b0, 32'h1000_0304, 32'h0, 4'hF, 32'h5A5A_0304, 1'b0, g);
    idle();
    @(negedge clk); #2;
    rst = 1'b1; flush = 1'b1;
    #1;
    sb.delete();
    chk("arst_perr", {31'b0, perr}, 32'd0);
    chk("arst_exit_valid", {31'b0, exit_valid}, 32'd0);
    chk("arst_exit_code", exit_code, 32'd0);
    chk("arst_char", {24'b0, char_v}, 32'd0);
    chk("arst_rvalid", {31'b0, data_rvalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; flush = 1'b0; lat[1] = 1;
    // Tracking was discarded: a stack access is accepted straight away.
    do_req(1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, g);
    chk("post_rst_stack_req", {31'b0, stack_req}, 32'd1);
    idle();
    drain();
    chk("post_rst_perr", {31'b0, perr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
